// File: rtl/ser_pkg.sv
// Shared types, constants and the bit-count legality check for the serializer scheduler.
package ser_pkg;

  typedef enum logic [1:0] {IDLE, START, ACK, RUN} ser_sched_state_t;

  localparam int SER_MOD_MIN     = 3;
  localparam int SER_MOD_MAX     = 16;
  localparam int SER_ACK_TIMEOUT = 2;

  // A mod of 0 encodes a full 16-bit word.
  function automatic logic ser_mod_legal(input logic [31:0] mod);
    return (mod == 32'd0) ||
           ((mod >= 32'(SER_MOD_MIN)) && (mod <= 32'(SER_MOD_MAX)));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting one past the last grant.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_val
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_val = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = IDX_W'((int'(last_gnt) + i) % N_CH);
      if (!gnt_val && req[cand]) begin
        gnt_val = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = gnt_val;
  end

endmodule

// File: rtl/ser_scheduler.sv
// Shares one serializer between N_CH requesters via per-channel holding registers.
// Optional build macro SER_SCHED_PRIO_EN makes channel 0 strict-priority.
module ser_scheduler #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int MOD_W  = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          req_val_i,
  input  logic [N_CH*DATA_W-1:0]   req_data_i,
  input  logic [N_CH*MOD_W-1:0]    req_mod_i,
  output logic [N_CH-1:0]          req_rdy_o,
  output logic [DATA_W-1:0]        ser_data_o,
  output logic [MOD_W-1:0]         ser_mod_o,
  output logic                     ser_val_o,
  input  logic                     ser_busy_i,
  output logic [$clog2(N_CH)-1:0]  gnt_id_o,
  output logic                     busy_o,
  output logic                     drop_o,
  output logic                     err_o
);

  import ser_pkg::*;

  localparam int IDX_W = $clog2(N_CH);

  ser_sched_state_t state_q, state_d;

  logic [N_CH-1:0]   hold_full;
  logic [DATA_W-1:0] hold_data [N_CH];
  logic [MOD_W-1:0]  hold_mod  [N_CH];
  logic [IDX_W-1:0]  last_gnt;

  logic [N_CH-1:0]   arb_req, arb_gnt, pick_sel;
  logic [IDX_W-1:0]  arb_idx, pick_idx;
  logic              arb_val, pick_val, pick_legal, last_upd;
  logic              grant, ack_expire, drop_q, err_q;
  logic [1:0]        ack_cnt;

  rr_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
    .req      (arb_req),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .gnt_val  (arb_val)
  );

`ifdef SER_SCHED_PRIO_EN
  // Channel 0 bypasses the rotation and leaves the pointer alone.
  assign arb_req  = hold_full & ~N_CH'(1);
  assign pick_sel = hold_full[0] ? N_CH'(1) : arb_gnt;
  assign pick_idx = hold_full[0] ? '0 : arb_idx;
  assign pick_val = hold_full[0] | arb_val;
  assign last_upd = ~hold_full[0];
`else
  assign arb_req  = hold_full;
  assign pick_sel = arb_gnt;
  assign pick_idx = arb_idx;
  assign pick_val = arb_val;
  assign last_upd = 1'b1;
`endif

  assign pick_legal = ser_mod_legal(32'(hold_mod[pick_idx]));
  assign req_rdy_o  = ~hold_full;
  assign ser_val_o  = (state_q == START);
  assign busy_o     = (state_q != IDLE);
  assign drop_o     = drop_q;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    ack_expire = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_val) begin
          grant   = 1'b1;
          state_d = pick_legal ? START : IDLE;
        end
      end
      START: state_d = ACK;
      ACK: begin
        if (ser_busy_i) begin
          state_d = RUN;
        end else if (ack_cnt == 2'(SER_ACK_TIMEOUT - 1)) begin
          ack_expire = 1'b1;
          state_d    = IDLE;
        end
      end
      RUN: if (!ser_busy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A granted register empties at the grant edge so the channel can refill during the frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_full <= '0;
      for (int c = 0; c < N_CH; c++) begin
        hold_data[c] <= '0;
        hold_mod[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (grant && pick_sel[c]) begin
          hold_full[c] <= 1'b0;
        end else if (req_val_i[c] && !hold_full[c]) begin
          hold_full[c] <= 1'b1;
          hold_data[c] <= req_data_i[c*DATA_W +: DATA_W];
          hold_mod[c]  <= req_mod_i[c*MOD_W +: MOD_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ser_data_o <= '0;
      ser_mod_o  <= '0;
      gnt_id_o   <= '0;
      last_gnt   <= IDX_W'(N_CH - 1);
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_cnt    <= '0;
    end else begin
      drop_q <= grant & ~pick_legal;
      if (grant) begin
        ser_data_o <= hold_data[pick_idx];
        ser_mod_o  <= hold_mod[pick_idx];
        gnt_id_o   <= pick_idx;
        if (last_upd) last_gnt <= pick_idx;
      end
      if (state_q == START)                  ack_cnt <= '0;
      else if (state_q == ACK && !ser_busy_i) ack_cnt <= ack_cnt + 2'd1;
      if (ack_expire) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ser_scheduler.sv
// Scoreboard bench for ser_scheduler: directed words in, expected starts/drops queued, monitor compares.
module tb_ser_scheduler;

  localparam int N_CH = 4;

  logic        clk_i, rst_i;
  logic [3:0]  req_val_i;
  logic [63:0] req_data_i;
  logic [19:0] req_mod_i;
  logic [3:0]  req_rdy_o;
  logic [15:0] ser_data_o;
  logic [4:0]  ser_mod_o;
  logic        ser_val_o, ser_busy_i, busy_o, drop_o, err_o;
  logic [1:0]  gnt_id_o;

  ser_scheduler #(.N_CH(4), .DATA_W(16), .MOD_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_val_i(req_val_i), .req_data_i(req_data_i), .req_mod_i(req_mod_i),
    .req_rdy_o(req_rdy_o), .ser_data_o(ser_data_o), .ser_mod_o(ser_mod_o),
    .ser_val_o(ser_val_o), .ser_busy_i(ser_busy_i), .gnt_id_o(gnt_id_o),
    .busy_o(busy_o), .drop_o(drop_o), .err_o(err_o)
  );

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [4:0]  mod;
    bit          chk_lat;
    int          gap;
    bit          timeout;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  exp_t cur;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int accept_cyc[4];
  int last_val_cyc = -100;
  int err_chk_cyc  = -100;
  int busy_len = 3;
  bit no_ack = 0;
  bit prev_val = 0, prev_drop = 0;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc = cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_start(input int id, input logic [15:0] d, input logic [4:0] m,
                              input bit lat, input int gap, input bit to);
    exp_t e;
    e.id = id; e.data = d; e.mod = m; e.chk_lat = lat; e.gap = gap; e.timeout = to;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input int ch, input logic [15:0] d, input logic [4:0] m);
    int budget = 0;
    @(negedge clk_i);
    while (!req_rdy_o[ch] && budget < 300) begin
      @(negedge clk_i);
      budget++;
    end
    if (!req_rdy_o[ch]) check_output("rdy_wait", 32'(req_rdy_o[ch]), 32'd1);
    req_val_i[ch] = 1'b1;
    req_data_i[ch*16 +: 16] = d;
    req_mod_i[ch*5 +: 5] = m;
    accept_cyc[ch] = cyc;
    @(negedge clk_i);
    req_val_i[ch] = 1'b0;
  endtask

  task automatic load_mask(input logic [3:0] mask, input logic [15:0] base, input logic [19:0] mods);
    @(negedge clk_i);
    for (int c = 0; c < N_CH; c++) begin
      if (mask[c]) begin
        req_val_i[c] = 1'b1;
        req_data_i[c*16 +: 16] = base + 16'(c);
        req_mod_i[c*5 +: 5] = mods[c*5 +: 5];
        accept_cyc[c] = cyc;
      end
    end
    @(negedge clk_i);
    req_val_i = '0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (!(busy_o == 1'b0 && req_rdy_o == 4'hF && exp_q.size() == 0 && drop_q.size() == 0)
           && budget < 400) begin
      @(negedge clk_i);
      budget++;
    end
    check_output("queue_drained", 32'(exp_q.size() + drop_q.size()), 32'd0);
    repeat (2) @(negedge clk_i);
  endtask

  // Serializer model: busy for busy_len cycles starting with the start-strobe cycle.
  initial begin
    int rem = 0;
    ser_busy_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        rem = 0;
        ser_busy_i = 1'b0;
      end else begin
        if (ser_val_o && !no_ack) rem = busy_len;
        if (rem > 0) begin
          ser_busy_i = 1'b1;
          rem--;
        end else begin
          ser_busy_i = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes a start or a drop.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i) begin
      if (prev_val)  check_output("val_one_cycle", 32'(ser_val_o), 32'd0);
      if (prev_drop) check_output("drop_one_cycle", 32'(drop_o), 32'd0);
      if (ser_val_o) begin
        check_output("start_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check_output("start_id", 32'(gnt_id_o), 32'(cur.id));
          check_output("start_data", 32'(ser_data_o), 32'(cur.data));
          check_output("start_mod", 32'(ser_mod_o), 32'(cur.mod));
          if (cur.chk_lat) check_output("start_latency", 32'(cyc - accept_cyc[cur.id]), 32'd2);
          if (cur.gap > 0) check_output("frame_gap", 32'(cyc - last_val_cyc), 32'(cur.gap));
          if (cur.timeout) err_chk_cyc = cyc + 3;
        end
        last_val_cyc = cyc;
      end
      if (busy_o && ser_busy_i) begin
        check_output("hold_data", 32'(ser_data_o), 32'(cur.data));
        check_output("hold_id", 32'(gnt_id_o), 32'(cur.id));
      end
      if (drop_o) begin
        check_output("drop_expected", 32'(drop_q.size() > 0), 32'd1);
        if (drop_q.size() > 0) check_output("drop_id", 32'(gnt_id_o), 32'(drop_q.pop_front()));
      end
      if (cyc == err_chk_cyc - 1) check_output("err_not_early", 32'(err_o), 32'd0);
      if (cyc == err_chk_cyc) begin
        check_output("err_set", 32'(err_o), 32'd1);
        check_output("idle_after_timeout", 32'(busy_o), 32'd0);
      end
      prev_val  = ser_val_o;
      prev_drop = drop_o;
    end else begin
      prev_val  = 1'b0;
      prev_drop = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d/%0d checks passed", n_pass, n_total + 1);
    $finish;
  end

  initial begin
    rst_i = 1'b1;
    req_val_i = '0;
    req_data_i = '0;
    req_mod_i = '0;
    repeat (3) @(negedge clk_i);
    check_output("rst_rdy", 32'(req_rdy_o), 32'hF);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_val", 32'(ser_val_o), 32'd0);
    check_output("rst_drop", 32'(drop_o), 32'd0);
    check_output("rst_err", 32'(err_o), 32'd0);
    check_output("rst_data", 32'(ser_data_o), 32'd0);
    check_output("rst_mod", 32'(ser_mod_o), 32'd0);
    check_output("rst_gnt", 32'(gnt_id_o), 32'd0);
    rst_i = 1'b0;

    $display("[TB] single word on ch1");
    busy_len = 4;
    expect_start(1, 16'hA5A5, 5'd8, 1, -1, 0);
    apply_stimulus(1, 16'hA5A5, 5'd8);
    wait_idle();

    // last_gnt is 1 here, so the full set rotates 2,3,0,1 then repeats.
    $display("[TB] fairness, all channels full");
    busy_len = 3;
    expect_start(2, 16'h1002, 5'd10, 0, -1, 0);
    expect_start(3, 16'h1003, 5'd0,  0, 5, 0);
    expect_start(0, 16'h1000, 5'd16, 0, 5, 0);
    expect_start(1, 16'h1001, 5'd5,  0, 5, 0);
    expect_start(2, 16'h2002, 5'd9,  0, 5, 0);
    expect_start(3, 16'h2003, 5'd15, 0, 5, 0);
    expect_start(0, 16'h2000, 5'd3,  0, 5, 0);
    expect_start(1, 16'h2001, 5'd7,  0, 5, 0);
    load_mask(4'hF, 16'h1000, {5'd0, 5'd10, 5'd5, 5'd16});
    apply_stimulus(2, 16'h2002, 5'd9);
    apply_stimulus(3, 16'h2003, 5'd15);
    apply_stimulus(0, 16'h2000, 5'd3);
    apply_stimulus(1, 16'h2001, 5'd7);
    wait_idle();

    $display("[TB] illegal and boundary mods");
    drop_q.push_back(2);
    apply_stimulus(2, 16'h0BAD, 5'd1);
    wait_idle();
    check_output("rdy_after_drop", 32'(req_rdy_o[2]), 32'd1);
    expect_start(2, 16'hBEEF, 5'd0, 0, -1, 0);
    apply_stimulus(2, 16'hBEEF, 5'd0);
    wait_idle();
    drop_q.push_back(3);
    apply_stimulus(3, 16'h0BAD, 5'd17);
    wait_idle();
    expect_start(0, 16'h0003, 5'd3, 0, -1, 0);
    apply_stimulus(0, 16'h0003, 5'd3);
    wait_idle();
    drop_q.push_back(1);
    apply_stimulus(1, 16'h0BAD, 5'd2);
    wait_idle();
    expect_start(1, 16'h0016, 5'd16, 0, -1, 0);
    apply_stimulus(1, 16'h0016, 5'd16);
    wait_idle();
    check_output("err_clear_before_timeout", 32'(err_o), 32'd0);

    $display("[TB] ack timeout");
    no_ack = 1;
    expect_start(1, 16'h1234, 5'd8, 0, -1, 1);
    apply_stimulus(1, 16'h1234, 5'd8);
    wait_idle();
    no_ack = 0;
    expect_start(3, 16'h5678, 5'd12, 0, -1, 0);
    apply_stimulus(3, 16'h5678, 5'd12);
    wait_idle();
    check_output("err_sticky", 32'(err_o), 32'd1);

    $display("[TB] reset during RUN");
    busy_len = 20;
    expect_start(2, 16'hCAFE, 5'd9, 0, -1, 0);
    apply_stimulus(2, 16'hCAFE, 5'd9);
    for (int k = 0; k < 50 && !(busy_o && ser_busy_i && !ser_val_o); k++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    apply_stimulus(1, 16'hDEAD, 5'd4);
    apply_stimulus(3, 16'hDEAD, 5'd4);
    check_output("busy_before_reset", 32'(busy_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check_output("async_rst_busy", 32'(busy_o), 32'd0);
    check_output("async_rst_rdy", 32'(req_rdy_o), 32'hF);
    check_output("async_rst_err", 32'(err_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    busy_len = 3;
    expect_start(0, 16'h7000, 5'd5,  0, -1, 0);
    expect_start(2, 16'h7002, 5'd11, 0, 5, 0);
    load_mask(4'b0101, 16'h7000, {5'd0, 5'd11, 5'd0, 5'd5});
    wait_idle();

    $display("[TB] channel 0 refilled each frame");
    @(negedge clk_i) rst_i = 1'b1;
    @(negedge clk_i) rst_i = 1'b0;
`ifdef SER_SCHED_PRIO_EN
    expect_start(0, 16'h5000, 5'd4, 0, -1, 0);
    expect_start(0, 16'h5100, 5'd6, 0, 5, 0);
    expect_start(0, 16'h5200, 5'd7, 0, 5, 0);
    expect_start(1, 16'h5001, 5'd5, 0, 5, 0);
    expect_start(2, 16'h5002, 5'd6, 0, 5, 0);
    expect_start(3, 16'h5003, 5'd7, 0, 5, 0);
`else
    expect_start(0, 16'h5000, 5'd4, 0, -1, 0);
    expect_start(1, 16'h5001, 5'd5, 0, 5, 0);
    expect_start(2, 16'h5002, 5'd6, 0, 5, 0);
    expect_start(3, 16'h5003, 5'd7, 0, 5, 0);
    expect_start(0, 16'h5100, 5'd6, 0, 5, 0);
    expect_start(0, 16'h5200, 5'd7, 0, 5, 0);
`endif
    load_mask(4'hF, 16'h5000, {5'd7, 5'd6, 5'd5, 5'd4});
    apply_stimulus(0, 16'h5100, 5'd6);
    apply_stimulus(0, 16'h5200, 5'd7);
    wait_idle();

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
